// File: rtl/snes_pkg.sv
// Shared definitions for the SNES pad link: FSM states, frame length and button bit positions.
// Imported by both the pad emulator and the host reader.
package snes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } snes_state_t;

  localparam int SNES_NBITS = 16;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

endpackage

// File: rtl/snes_sync_edge.sv
// Synchroniser for one asynchronous host pin followed by a registered edge detector.
// level, rise and fall are all flop outputs, so pin-to-pulse latency is STAGES + 1 cycles.
module snes_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/snes_pad_emu.sv
// Device end of the SNES pad serial link: latches the button word and shifts it out
// LSB first, active-low, against the host's latch and shift clock.
//
//   state | meaning
//   IDLE  | no frame in flight, data line held high
//   LOAD  | host latch high, shift register tracks ~buttons every cycle
//   SHIFT | frame frozen, one bit advanced per snes_clk rise, stall timer running
module snes_pad_emu
  import snes_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snes_latch,
  input  logic                  snes_clk,
  input  logic [SNES_NBITS-1:0] buttons,
  output logic                  snes_data,
  output logic                  frame_done,
  output logic                  proto_err
);

  localparam int TCW = $clog2(TIMEOUT_CYC);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     BIT_LAST = 4'(SNES_NBITS - 1);

  logic latch_s, latch_rise, latch_fall;
  logic clk_s, clk_rise, clk_fall;
  logic unused_levels;

  snes_state_t           state;
  logic [SNES_NBITS-1:0] shreg;
  logic [3:0]            bcnt;
  logic [TCW-1:0]        tcnt;

  snes_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .clk      (clk),
    .rst      (rst),
    .async_in (snes_latch),
    .level    (latch_s),
    .rise     (latch_rise),
    .fall     (latch_fall)
  );

  snes_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk      (clk),
    .rst      (rst),
    .async_in (snes_clk),
    .level    (clk_s),
    .rise     (clk_rise),
    .fall     (clk_fall)
  );

  // The FSM is purely edge driven; the synchronised levels are kept for debug taps.
  assign unused_levels = latch_s ^ clk_s ^ clk_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snes_data  <= 1'b1;
      shreg      <= '1;
      bcnt       <= '0;
      tcnt       <= '0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
      case (state)
        IDLE: begin
          snes_data <= 1'b1;
          if (latch_rise) state <= LOAD;
        end

        LOAD: begin
          shreg     <= ~buttons;
          snes_data <= ~buttons[BTN_B];
          if (clk_rise) proto_err <= 1'b1;
          if (latch_fall) begin
            state <= SHIFT;
            bcnt  <= '0;
            tcnt  <= '0;
          end
        end

        SHIFT: begin
          // A latch restart takes priority and swallows a coincident clock edge.
          if (latch_rise) begin
            proto_err <= 1'b1;
            state     <= LOAD;
          end else if (clk_rise) begin
            tcnt <= '0;
            if (bcnt == BIT_LAST) begin
              snes_data  <= 1'b1;
              shreg      <= '1;
              frame_done <= 1'b1;
              bcnt       <= '0;
              state      <= IDLE;
            end else begin
              shreg     <= {1'b1, shreg[SNES_NBITS-1:1]};
              snes_data <= shreg[1];
              bcnt      <= bcnt + 4'd1;
            end
          end else if (tcnt == TO_LAST) begin
            proto_err <= 1'b1;
            snes_data <= 1'b1;
            state     <= IDLE;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + TCW'(1);
          end
        end

        default: begin
          state     <= IDLE;
          snes_data <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snes_pad_emu.sv
// Directed bench for snes_pad_emu: table of whole frames plus hand sequences for
// latency, latch restart, clock-during-latch, stalled host and mid-frame reset.
module tb_snes_pad_emu;

  localparam int T_OUT = 1000;
  localparam int LATCH = 120;
  localparam int H     = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snes_latch = 1'b0;
  logic        snes_clk = 1'b1;
  logic [15:0] buttons = 16'h0000;
  logic        snes_data;
  logic        frame_done;
  logic        proto_err;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;

  snes_pad_emu #(.SYNC_STAGES(2), .TIMEOUT_CYC(T_OUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .snes_latch (snes_latch),
    .snes_clk   (snes_clk),
    .buttons    (buttons),
    .snes_data  (snes_data),
    .frame_done (frame_done),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (proto_err)  pe_cnt <= pe_cnt + 1;
  end

  typedef struct {
    logic [15:0] btn;
    int          chg_at;
    logic [15:0] chg_val;
    logic [15:0] exp_bits;
  } frame_vec_t;

  frame_vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latch_pulse();
    snes_latch = 1'b1;
    tick(LATCH);
    snes_latch = 1'b0;
  endtask

  task automatic clk_pulse(output logic smp);
    tick(H);
    smp = snes_data;
    snes_clk = 1'b0;
    tick(H);
    snes_clk = 1'b1;
  endtask

  task automatic shift_bits(input int chg_at, input logic [15:0] chg_val,
                            output logic [15:0] bits);
    logic s;
    for (int i = 0; i < 16; i++) begin
      clk_pulse(s);
      bits[i] = s;
      if (i + 1 == chg_at) buttons = chg_val;
    end
    tick(H);
  endtask

  initial begin
    logic [15:0] bits;
    logic        s;
    int          fd0, pe0, waited;

    vecs[0] = '{btn: 16'h8101, chg_at: -1, chg_val: 16'h0000, exp_bits: 16'h7EFE};
    vecs[1] = '{btn: 16'h0000, chg_at: 3,  chg_val: 16'hFFFF, exp_bits: 16'hFFFF};
    vecs[2] = '{btn: 16'hFFFF, chg_at: -1, chg_val: 16'h0000, exp_bits: 16'h0000};
    vecs[3] = '{btn: 16'hA5C3, chg_at: -1, chg_val: 16'h0000, exp_bits: 16'h5A3C};
    vecs[4] = '{btn: 16'h1234, chg_at: -1, chg_val: 16'h0000, exp_bits: 16'hEDCB};

    tick(5);
    rst = 1'b0;
    tick(10);
    chk("reset_data", 32'(snes_data), 32'd1);
    chk("reset_fd_cnt", fd_cnt, 0);
    chk("reset_pe_cnt", pe_cnt, 0);

    for (int v = 0; v < 5; v++) begin
      buttons = vecs[v].btn;
      fd0 = fd_cnt;
      pe0 = pe_cnt;
      latch_pulse();
      shift_bits(vecs[v].chg_at, vecs[v].chg_val, bits);
      chk($sformatf("vec%0d_bits", v), 32'(bits), 32'(vecs[v].exp_bits));
      chk($sformatf("vec%0d_frame_done", v), fd_cnt - fd0, 1);
      chk($sformatf("vec%0d_proto_err", v), pe_cnt - pe0, 0);
      chk($sformatf("vec%0d_idle_data", v), 32'(snes_data), 32'd1);
    end

    // Pin-to-data latency on latch fall and on the first shift edge
    buttons = 16'h8101;
    fd0 = fd_cnt;
    snes_latch = 1'b1;
    tick(LATCH);
    snes_latch = 1'b0;
    tick(4);
    chk("lat_latch_bit0", 32'(snes_data), 32'd0);
    tick(H);
    snes_clk = 1'b0;
    tick(H);
    snes_clk = 1'b1;
    tick(3);
    chk("lat_clk_3cyc_old", 32'(snes_data), 32'd0);
    tick(1);
    chk("lat_clk_4cyc_new", 32'(snes_data), 32'd1);
    for (int i = 1; i < 16; i++) clk_pulse(s);
    tick(H);
    chk("lat_frame_done", fd_cnt - fd0, 1);

    // Latch restart after 5 bits
    buttons = 16'h00FF;
    latch_pulse();
    for (int i = 0; i < 5; i++) clk_pulse(s);
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    buttons = 16'h5A3C;
    latch_pulse();
    shift_bits(-1, 16'h0000, bits);
    chk("restart_proto_err", pe_cnt - pe0, 1);
    chk("restart_bits", 32'(bits), 32'h0000A5C3);
    chk("restart_frame_done", fd_cnt - fd0, 1);

    // Shift clock pulse while latch is high
    buttons = 16'h0F0F;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    snes_latch = 1'b1;
    tick(LATCH / 2);
    snes_clk = 1'b0;
    tick(H);
    snes_clk = 1'b1;
    tick(LATCH / 2);
    snes_latch = 1'b0;
    shift_bits(-1, 16'h0000, bits);
    chk("loadclk_proto_err", pe_cnt - pe0, 1);
    chk("loadclk_bits", 32'(bits), 32'h0000F0F0);
    chk("loadclk_frame_done", fd_cnt - fd0, 1);

    // Stalled host after 8 bits
    buttons = 16'hFFFF;
    fd0 = fd_cnt;
    latch_pulse();
    for (int i = 0; i < 8; i++) clk_pulse(s);
    pe0 = pe_cnt;
    waited = -1;
    for (int i = 1; i <= T_OUT + 100; i++) begin
      tick(1);
      if (proto_err) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL stall_timeout: no proto_err within %0d cycles", T_OUT + 100);
    end else begin
      chk("stall_delay_window", 32'((waited >= T_OUT) && (waited <= T_OUT + 8)), 32'd1);
    end
    tick(5);
    chk("stall_pe_pulses", pe_cnt - pe0, 1);
    chk("stall_data", 32'(snes_data), 32'd1);
    chk("stall_state", 32'(dut.state), 32'(snes_pkg::IDLE));
    chk("stall_no_frame_done", fd_cnt - fd0, 0);
    pe0 = pe_cnt;
    clk_pulse(s);
    tick(10);
    chk("idle_clk_no_err", pe_cnt - pe0, 0);

    // Reset mid-SHIFT
    buttons = 16'hFFFF;
    latch_pulse();
    for (int i = 0; i < 5; i++) clk_pulse(s);
    tick(H);
    chk("rst_pre_data", 32'(snes_data), 32'd0);
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_data_next", 32'(snes_data), 32'd1);
    shift_bits(-1, 16'h0000, bits);
    chk("rst_bits", 32'(bits), 32'h0000FFFF);
    chk("rst_no_frame_done", fd_cnt - fd0, 0);
    chk("rst_no_proto_err", pe_cnt - pe0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snes_pad_emu.md
# snes_pad_emu

Controller-side emulator of the SNES gamepad serial protocol: the device end of the link that our host reader drives. It accepts the host's `snes_latch` and `snes_clk`, which are asynchronous to `clk`, and returns a 16-bit button frame on `snes_data`, LSB (B) first and active-low on the wire. It sits between a button source (switches, another core or a test pattern) and the SNES connector pins. It also lets the reader be tested in loopback on one board.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on `snes_latch` and `snes_clk`; minimum 2.
- `TIMEOUT_CYC`, default 100000: `clk` cycles without a `snes_clk` rise in SHIFT before the frame is aborted (1 ms at 100 MHz).
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, synchronous and active-high.
- `snes_latch`  in  1  host latch, asynchronous.
- `snes_clk`  in  1  host shift clock, asynchronous; idles high.
- `buttons`  in  16  button state, 1 = pressed; bit 0 = B, 1 = Y, 2 = Select, 3 = Start, 4–7 = Up/Down/Left/Right, 8 = A, 9 = X, 10 = L, 11 = R, 12–15 = ID bits.
- `snes_data`  out  1  serial data, 0 = pressed; registered.
- `frame_done`  out  1  one-cycle pulse when the 16th bit has been shifted past.
- `proto_err`  out  1  one-cycle pulse on a protocol violation.

## Operation
- Each of `snes_latch` and `snes_clk` is passed through SYNC_STAGES flops, then a one-flop edge detector. This produces `latch_s`, `latch_rise`, `latch_fall` and `clk_rise`.
- Reset: state = IDLE, `snes_data` = 1, `shreg` = 16'hFFFF, bit count = 0, timeout count = 0, `frame_done` = 0, `proto_err` = 0.
- IDLE: `snes_data` = 1. A `clk_rise` is ignored and raises no error. `latch_rise` moves the block to LOAD.
- LOAD: every cycle `shreg` <= ~`buttons` and `snes_data` <= ~`buttons[0]`, so the parallel load is transparent. A `clk_rise` while in LOAD pulses `proto_err` and is otherwise ignored. `latch_fall` moves the block to SHIFT with count = 0. The frame is frozen at the value loaded in the last LOAD cycle.
- SHIFT: on each `clk_rise`, `shreg` <= {1'b1, `shreg[15:1]`}, `snes_data` <= `shreg[1]`, count++ and the timeout count clears. Every other cycle the timeout count increments.
- SHIFT, 16th `clk_rise` (count == 15): `snes_data` <= 1, `frame_done` pulses and the state goes to IDLE.
- SHIFT, `latch_rise`: `proto_err` pulses and the state goes to LOAD to restart. If `latch_rise` and `clk_rise` occur in the same cycle, latch wins and the clock edge is discarded.
- SHIFT, timeout count reaches TIMEOUT_CYC − 1: `proto_err` pulses, `snes_data` <= 1 and the state goes to IDLE.
- `buttons` is sampled only in LOAD; changes during SHIFT do not affect the frame in flight.
- Counter widths: bit count is 4 bits; timeout count is `$clog2(TIMEOUT_CYC)` bits and saturates, never wrapping.

## Timing
- Input edge to `snes_data` update: SYNC_STAGES + 2 `clk` cycles (4 at default).
- Host timing is a 12 µs latch and 6 µs `snes_clk` period, with sampling on the falling edge. Data is therefore stable more than 290 cycles before the host samples.
- `frame_done` is asserted in the same cycle that `snes_data` returns to 1.
- Reset asserted mid-frame takes effect on the next `clk` edge: `snes_data` = 1, no `frame_done`, no `proto_err`.

## Structure
- Package `snes_pkg` holds:
  - the state enum {IDLE, LOAD, SHIFT};
  - `SNES_NBITS` = 16;
  - the button index constants (`BTN_B` … `BTN_R`).
- The host reader imports `snes_pkg` as well.
- Sub-module `snes_sync_edge` (parameter STAGES; outputs `level`, `rise`, `fall`) is instantiated twice.
- FSM, shift register and counters stay in `snes_pad_emu`.

## Test plan
- Nominal frame: `buttons` = 16'h8101, one 12 µs latch, then 16 `snes_clk` pulses at 6 µs. Bits sampled on `snes_clk` falls must read 0,1,1,1,1,1,1,1,0,1,1,1,1,1,1,0. `snes_data` must then be 1, with one `frame_done` pulse and no `proto_err`.
- Latency: on `latch_fall`, `snes_data` must equal ~`buttons[0]` exactly 4 `clk` cycles after the pin edge; on each `clk_rise`, the next bit must likewise appear exactly 4 cycles after the pin edge.
- Button change mid-frame: `buttons` changes from 16'h0000 to 16'hFFFF after the 3rd `snes_clk` pulse. All 16 sampled bits must be 1.
- Latch restart: a second latch after 5 bits must produce one `proto_err` pulse. The frame then restarts from bit 0 with the new `buttons` value.
- Stalled host: stop `snes_clk` after 8 bits. After 100000 cycles there must be one `proto_err` pulse, `snes_data` = 1, and the state must be IDLE.
- Reset: assert `rst` for 1 cycle mid-SHIFT. `snes_data` must be 1 on the next cycle, and 16 extra clock pulses must yield all 1s with no `frame_done`.
